serial_sub_4: RTL and testbench



---
 rtl/serial_sub_4.sv | 126 ++++++++++++
 tb/tb_serial_sub_4.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_4.sv
// rtl/serial_sub_4.sv - bit-serial subtractor computing a - b - BIN one bit per clock, LSB first
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request pulse, honoured only in IDLE or DONE
//   a      in   WIDTH-bit minuend, captured on an accepted start
//   b      in   WIDTH-bit subtrahend, captured on an accepted start
//   BIN    in   borrow-in, captured on an accepted start
//   busy   out  high while a subtraction is in progress
//   done   out  one-cycle pulse, d/bout valid
//   d      out  WIDTH-bit difference, held until the next completion
//   bout   out  borrow-out, held with d

module serial_sub_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             BIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q;
    logic [WIDTH-1:0] temp_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;

    logic accept;
    logic last_bit;
    logic ai, bi;
    logic diff_bit;
    logic br_next;

    // DONE is a one-cycle state that can launch the next operation directly,
    // which is what gives back-to-back operation without an idle bubble.
    assign accept   = start && (state_q != S_RUN);
    assign last_bit = (state_q == S_RUN) && (cnt_q == CNT_LAST);

    // Single full-subtractor cell working on the LSBs of the shift registers.
    assign ai       = a_sr_q[0];
    assign bi       = b_sr_q[0];
    assign diff_bit = ai ^ bi ^ br_q;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q <= '0;
            b_sr_q <= '0;
            temp_q <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
        end else if (accept) begin
            a_sr_q <= a;
            b_sr_q <= b;
            temp_q <= '0;
            br_q   <= BIN;
            cnt_q  <= '0;
        end else if (state_q == S_RUN) begin
            a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
            // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
            temp_q <= {diff_bit, temp_q[WIDTH-1:1]};
            br_q   <= br_next;
            // Return to zero after the last bit rather than wrapping.
            cnt_q  <= last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    // The visible result is updated only on the edge that enters DONE, taking
    // the final bit straight from the cell so intermediate bits never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (last_bit) begin
            d_q    <= {diff_bit, temp_q[WIDTH-1:1]};
            bout_q <= br_next;
        end
    end

    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_4.sv
// tb/tb_serial_sub_4.sv - self-checking bench for serial_sub_4 against an arithmetic reference model

module tb_serial_sub_4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       BIN;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       bout;

    int n_checks;
    int n_pass;

    serial_sub_4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .BIN   (BIN),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction taken modulo 32 gives {bout, d}.
    function automatic logic [4:0] model(input int x, input int y, input int z);
        int r;
        r = x - y - z;
        return r[4:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and waits (bounded) for done. lat is the number
    // of edges from acceptance to done (-1 if it never came), bcnt the number
    // of sampled busy cycles, early set if d/bout moved before done.
    task automatic run_op(input logic [3:0] xa, input logic [3:0] xb, input logic xbin,
                          output int lat, output int bcnt, output logic early);
        logic [3:0] d0;
        logic       b0;
        d0    = d;
        b0    = bout;
        early = 1'b0;
        lat   = -1;
        bcnt  = 0;
        a     = xa;
        b     = xb;
        BIN   = xbin;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0;
            a     = 4'($urandom);
            b     = 4'($urandom);
            BIN   = 1'($urandom);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            if (d !== d0 || bout !== b0) early = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; BIN = 1'b0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
        n_checks++; if (d !== 4'd0)    $display("FAIL reset_d got=%0d exp=0", d); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL reset_bout got=%0b exp=0", bout); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic early;
        run_op(4'd10, 4'd9, 1'b1, lat, bcnt, early);
        n_checks++; if (lat !== 5)       $display("FAIL basic1_latency got=%0d exp=5", lat); else n_pass++;
        n_checks++; if (bcnt !== 4)      $display("FAIL basic1_busy_cycles got=%0d exp=4", bcnt); else n_pass++;
        n_checks++; if (early !== 1'b0)  $display("FAIL basic1_early_update got=%0b exp=0", early); else n_pass++;
        n_checks++; if (d !== 4'd0)      $display("FAIL basic1_d got=%0d exp=0", d); else n_pass++;
        n_checks++; if (bout !== 1'b0)   $display("FAIL basic1_bout got=%0b exp=0", bout); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0)   $display("FAIL basic1_done_pulse got=%0b exp=0", done); else n_pass++;
        run_op(4'd6, 4'd8, 1'b1, lat, bcnt, early);
        n_checks++; if (lat !== 5)       $display("FAIL basic2_latency got=%0d exp=5", lat); else n_pass++;
        n_checks++; if (early !== 1'b0)  $display("FAIL basic2_early_update got=%0b exp=0", early); else n_pass++;
        n_checks++; if (d !== 4'd13)     $display("FAIL basic2_d got=%0d exp=13", d); else n_pass++;
        n_checks++; if (bout !== 1'b1)   $display("FAIL basic2_bout got=%0b exp=1", bout); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic early;
        int k2;
        run_op(4'd5, 4'd7, 1'b0, lat, bcnt, early);
        // Now in the DONE cycle: hold start so the next op launches from DONE.
        a = 4'd0; b = 4'd15; BIN = 1'b1; start = 1'b1;
        n_checks++; if (lat !== 5)     $display("FAIL b2b_first_latency got=%0d exp=5", lat); else n_pass++;
        n_checks++; if (d !== 4'd14)   $display("FAIL b2b_first_d got=%0d exp=14", d); else n_pass++;
        n_checks++; if (bout !== 1'b1) $display("FAIL b2b_first_bout got=%0b exp=1", bout); else n_pass++;
        k2 = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            start = 1'b0;
            if (k == 1) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL b2b_no_bubble busy=%0b exp=1", busy); else n_pass++;
                n_checks++; if (done !== 1'b0) $display("FAIL b2b_done_consecutive got=%0b exp=0", done); else n_pass++;
            end
            if (done) begin
                k2 = k;
                break;
            end
        end
        n_checks++; if (k2 !== 5)      $display("FAIL b2b_second_spacing got=%0d exp=5", k2); else n_pass++;
        n_checks++; if (d !== 4'd0)    $display("FAIL b2b_second_d got=%0d exp=0", d); else n_pass++;
        n_checks++; if (bout !== 1'b1) $display("FAIL b2b_second_bout got=%0b exp=1", bout); else n_pass++;
        tick();
    endtask

    task automatic test_start_while_busy();
        int ndone;
        a = 4'd15; b = 4'd1; BIN = 1'b0; start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (done) ndone++;
            // Keep hammering start with junk operands while busy; release it once done shows.
            start = busy;
            a = 4'($urandom); b = 4'($urandom); BIN = 1'($urandom);
            if (k == 5) begin
                n_checks++; if (done !== 1'b1) $display("FAIL busy_start_done_at_5 got=%0b exp=1", done); else n_pass++;
                n_checks++; if (d !== 4'd14)   $display("FAIL busy_start_d got=%0d exp=14", d); else n_pass++;
                n_checks++; if (bout !== 1'b0) $display("FAIL busy_start_bout got=%0b exp=0", bout); else n_pass++;
            end
        end
        n_checks++; if (ndone !== 1) $display("FAIL busy_start_done_count got=%0d exp=1", ndone); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt;
        logic early;
        int ndone;
        a = 4'd3; b = 4'd4; BIN = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL midrst_done got=%0b exp=0", done); else n_pass++;
        n_checks++; if (d !== 4'd0)    $display("FAIL midrst_d got=%0d exp=0", d); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL midrst_bout got=%0b exp=0", bout); else n_pass++;
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        n_checks++; if (ndone !== 0) $display("FAIL midrst_activity_after got=%0d exp=0", ndone); else n_pass++;
        run_op(4'd9, 4'd4, 1'b0, lat, bcnt, early);
        n_checks++; if (lat !== 5)     $display("FAIL midrst_next_latency got=%0d exp=5", lat); else n_pass++;
        n_checks++; if (d !== 4'd5)    $display("FAIL midrst_next_d got=%0d exp=5", d); else n_pass++;
        n_checks++; if (bout !== 1'b0) $display("FAIL midrst_next_bout got=%0b exp=0", bout); else n_pass++;
        tick();
    endtask

    task automatic test_sweep();
        int lat, bcnt;
        logic early;
        logic [4:0] exp;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            exp = model(int'(v[3:0]), int'(v[7:4]), int'(v[8]));
            run_op(v[3:0], v[7:4], v[8], lat, bcnt, early);
            n_checks++;
            if (lat !== 5 || {bout, d} !== exp)
                $display("FAIL sweep a=%0d b=%0d bin=%0d got lat=%0d res=%0h exp lat=5 res=%0h",
                         v[3:0], v[7:4], v[8], lat, {bout, d}, exp);
            else n_pass++;
            if (i[0]) tick();
        end
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic early;
        logic [3:0] ra, rb;
        logic       rbin;
        logic [4:0] exp;
        for (int i = 0; i < 60; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rbin = 1'($urandom);
            exp = model(int'(ra), int'(rb), int'(rbin));
            run_op(ra, rb, rbin, lat, bcnt, early);
            n_checks++;
            if (lat !== 5 || bcnt !== 4 || early !== 1'b0 || {bout, d} !== exp)
                $display("FAIL random a=%0d b=%0d bin=%0d got lat=%0d busy=%0d early=%0b res=%0h exp lat=5 busy=4 early=0 res=%0h",
                         ra, rb, rbin, lat, bcnt, early, {bout, d}, exp);
            else n_pass++;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_run();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
